// File: rtl/echo_ind_pkg.sv
// Shared constants for the echo indication serializer: method tags and
// message/beat geometry derived from the argument and beat widths.
package echo_ind_pkg;

    localparam int unsigned TAG_W = 32;

    localparam logic [TAG_W-1:0] TAG_SAY  = 32'd1;
    localparam logic [TAG_W-1:0] TAG_SAY2 = 32'd2;

    // Message is a tag word followed by two method arguments.
    function automatic int unsigned calc_msg_w(input int unsigned data_w);
        return TAG_W + 2 * data_w;
    endfunction

    function automatic int unsigned calc_beats(input int unsigned msg_w, input int unsigned out_w);
        return msg_w / out_w;
    endfunction

endpackage

// File: rtl/echo_msg_fifo.sv
// Message FIFO for the serializer; pointers reset, storage array does not.
module echo_msg_fifo #(
    parameter int unsigned MSG_W = 96,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [MSG_W-1:0] push_data_i,
    input  logic             pop_i,
    output logic [MSG_W-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [MSG_W-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_d = wr_q + PW'(push_ok);
        rd_d = rd_q + PW'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/echo_indication_serializer.sv
// Packs say/say2 method calls into tagged messages, queues them and streams
// each message out LSB-first as OUT_W-wide beats with a last marker.
module echo_indication_serializer
    import echo_ind_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              say__ENA,
    input  logic [DATA_W-1:0] say_meth,
    input  logic [DATA_W-1:0] say_v,
    output logic              say__RDY,
    input  logic              say2__ENA,
    input  logic [DATA_W-1:0] say2_a,
    input  logic [DATA_W-1:0] say2_b,
    output logic              say2__RDY,
    output logic              pipe_enq__ENA,
    output logic [OUT_W-1:0]  pipe_enq_v,
    output logic              pipe_enq_last,
    input  logic              pipe_enq__RDY,
    output logic [15:0]       msg_sent
);

    localparam int unsigned MSG_W  = calc_msg_w(DATA_W);
    localparam int unsigned BEATS  = calc_beats(MSG_W, OUT_W);
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [15:0]       sent_q, sent_d;
    logic [MSG_W-1:0]  head;
    logic [MSG_W-1:0]  push_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept_say;
    logic              accept_say2;
    logic              push;
    logic              pop;
    logic              beat_fire;
    logic              is_last;

    // say wins a same-cycle collision, so say2 is held off combinationally.
    assign say__RDY    = !fifo_full;
    assign say2__RDY   = !fifo_full && !say__ENA;
    assign accept_say  = say__ENA && say__RDY;
    assign accept_say2 = say2__ENA && say2__RDY;
    assign push        = accept_say || accept_say2;
    assign push_data   = accept_say ? {say_v, say_meth, TAG_SAY}
                                    : {say2_b, say2_a, TAG_SAY2};

    assign is_last       = (beat_q == BEAT_W'(BEATS - 1));
    assign pipe_enq__ENA = !fifo_empty;
    assign pipe_enq_last = !fifo_empty && is_last;
    assign pipe_enq_v    = OUT_W'(head >> (OUT_W * beat_q));
    assign beat_fire     = pipe_enq__ENA && pipe_enq__RDY;
    assign pop           = beat_fire && is_last;
    assign msg_sent      = sent_q;

    echo_msg_fifo #(
        .MSG_W (MSG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (CLK),
        .rst         (nRST),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Beat index only moves on an accepted beat; the head pops on the last one.
    always_comb begin
        beat_d = beat_q;
        sent_d = sent_q;
        if (beat_fire) begin
            if (is_last) begin
                beat_d = '0;
                sent_d = sent_q + 16'd1;
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            beat_q <= '0;
            sent_q <= '0;
        end else begin
            beat_q <= beat_d;
            sent_q <= sent_d;
        end
    end

endmodule

// File: tb/tb_echo_indication_serializer.sv
// Scoreboard bench: default-geometry instance (3 beats/message) and a
// 48-bit argument / 64-bit beat instance (2 beats/message).
module tb_echo_indication_serializer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_say_ena, a_say2_ena, a_say_rdy, a_say2_rdy;
    logic [31:0] a_say_meth, a_say_v, a_say2_a, a_say2_b;
    logic        a_enq_ena, a_enq_last, a_enq_rdy;
    logic [31:0] a_enq_v;
    logic [15:0] a_sent;

    logic        b_say_ena, b_say2_ena, b_say_rdy, b_say2_rdy;
    logic [47:0] b_say_meth, b_say_v, b_say2_a, b_say2_b;
    logic        b_enq_ena, b_enq_last, b_enq_rdy;
    logic [63:0] b_enq_v;
    logic [15:0] b_sent;

    int checks = 0;
    int failures = 0;
    logic [64:0] qa[$];
    logic [64:0] qb[$];

    echo_indication_serializer #(.DATA_W(32), .OUT_W(32), .DEPTH(4)) u_dut_a (
        .CLK(clk), .nRST(rst),
        .say__ENA(a_say_ena), .say_meth(a_say_meth), .say_v(a_say_v), .say__RDY(a_say_rdy),
        .say2__ENA(a_say2_ena), .say2_a(a_say2_a), .say2_b(a_say2_b), .say2__RDY(a_say2_rdy),
        .pipe_enq__ENA(a_enq_ena), .pipe_enq_v(a_enq_v), .pipe_enq_last(a_enq_last),
        .pipe_enq__RDY(a_enq_rdy), .msg_sent(a_sent)
    );

    echo_indication_serializer #(.DATA_W(48), .OUT_W(64), .DEPTH(4)) u_dut_b (
        .CLK(clk), .nRST(rst),
        .say__ENA(b_say_ena), .say_meth(b_say_meth), .say_v(b_say_v), .say__RDY(b_say_rdy),
        .say2__ENA(b_say2_ena), .say2_a(b_say2_a), .say2_b(b_say2_b), .say2__RDY(b_say2_rdy),
        .pipe_enq__ENA(b_enq_ena), .pipe_enq_v(b_enq_v), .pipe_enq_last(b_enq_last),
        .pipe_enq__RDY(b_enq_rdy), .msg_sent(b_sent)
    );

    function automatic void check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor A: compare presented beat with scoreboard head; pop on handshake.
    always @(negedge clk) begin
        if (!rst && a_enq_ena) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_beat: got %0h expected no beat", a_enq_v);
            end else if (a_enq_rdy) begin
                check("a_beat", {a_enq_last, 32'h0, a_enq_v}, qa[0]);
                qa.delete(0);
            end else begin
                check("a_hold", {a_enq_last, 32'h0, a_enq_v}, qa[0]);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_enq_ena) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_beat: got %0h expected no beat", b_enq_v);
            end else if (b_enq_rdy) begin
                check("b_beat", {b_enq_last, b_enq_v}, qb[0]);
                qb.delete(0);
            end else begin
                check("b_hold", {b_enq_last, b_enq_v}, qb[0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_exp(input logic [31:0] tag, input logic [31:0] x, input logic [31:0] y);
        qa.push_back({1'b0, 32'h0, tag});
        qa.push_back({1'b0, 32'h0, x});
        qa.push_back({1'b1, 32'h0, y});
    endtask

    // One-cycle say call on A; checks RDY and queues the message if accepted.
    task automatic a_say(input logic [31:0] meth, input logic [31:0] v, input logic exp_rdy);
        a_say_ena  = 1'b1;
        a_say_meth = meth;
        a_say_v    = v;
        #1;
        check("a_say_rdy", 65'(a_say_rdy), 65'(exp_rdy));
        if (exp_rdy) a_exp(32'd1, meth, v);
        tick();
        a_say_ena = 1'b0;
    endtask

    task automatic drain(input int limit, input bit toggle);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < limit) begin
            tick();
            if (toggle) a_enq_rdy = ~a_enq_rdy;
            n++;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d/%0d beats left expected 0", qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
        a_enq_rdy = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        a_say_ena = 0; a_say2_ena = 0; a_enq_rdy = 1;
        a_say_meth = 0; a_say_v = 0; a_say2_a = 0; a_say2_b = 0;
        b_say_ena = 0; b_say2_ena = 0; b_enq_rdy = 1;
        b_say_meth = 0; b_say_v = 0; b_say2_a = 0; b_say2_b = 0;
        #2;
        check("rst_enq_ena", 65'(a_enq_ena), 65'(0));
        check("rst_enq_last", 65'(a_enq_last), 65'(0));
        check("rst_say_rdy", 65'(a_say_rdy), 65'(1));
        check("rst_say2_rdy", 65'(a_say2_rdy), 65'(1));
        check("rst_msg_sent", 65'(a_sent), 65'(0));
        a_say_ena = 1'b1;
        #1;
        check("rst_say2_rdy_blocked", 65'(a_say2_rdy), 65'(0));
        a_say_ena = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Wide instance: say2 then say, 2 beats each.
        b_say2_ena = 1'b1; b_say2_a = 48'hAAAA; b_say2_b = 48'hBBBB;
        qb.push_back({1'b0, 64'h0000AAAA_00000002});
        qb.push_back({1'b1, 64'h00000000_BBBB0000});
        tick();
        b_say2_ena = 1'b0;
        b_say_ena = 1'b1; b_say_meth = 48'h1234_5678_9ABC; b_say_v = 48'hFEDC_BA98_7654;
        qb.push_back({1'b0, 64'h56789ABC_00000001});
        qb.push_back({1'b1, 64'hFEDCBA98_76541234});
        tick();
        b_say_ena = 1'b0;
        drain(50, 1'b0);
        check("b_msg_sent", 65'(b_sent), 65'(2));

        // Basic say: 0x1, 0x5, 0x1234.
        a_say(32'd5, 32'h1234, 1'b1);
        drain(50, 1'b0);
        check("a_msg_sent_basic", 65'(a_sent), 65'(1));

        // Collision: say wins, say2 retried next cycle.
        a_say_ena = 1'b1; a_say_meth = 32'd7; a_say_v = 32'd8;
        a_say2_ena = 1'b1; a_say2_a = 32'h22; a_say2_b = 32'h33;
        #1;
        check("collide_say_rdy", 65'(a_say_rdy), 65'(1));
        check("collide_say2_rdy", 65'(a_say2_rdy), 65'(0));
        a_exp(32'd1, 32'd7, 32'd8);
        tick();
        a_say_ena = 1'b0;
        #1;
        check("retry_say2_rdy", 65'(a_say2_rdy), 65'(1));
        a_exp(32'd2, 32'h22, 32'h33);
        tick();
        a_say2_ena = 1'b0;
        drain(50, 1'b0);
        check("a_msg_sent_collide", 65'(a_sent), 65'(3));

        // Back-pressure fill: fifth call refused, then 12 beats in 12 cycles.
        a_enq_rdy = 1'b0;
        for (int i = 0; i < 5; i++) a_say(32'(i + 1), 32'h100 + 32'(i), i < 4);
        a_enq_rdy = 1'b1;
        n = 0;
        while (qa.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check("burst_cycles", 65'(n), 65'(12));
        check("burst_idle", 65'(a_enq_ena), 65'(0));
        tick();
        check("a_msg_sent_burst", 65'(a_sent), 65'(7));

        // Full with a pop on the same edge: no bypass push.
        a_enq_rdy = 1'b0;
        for (int i = 0; i < 4; i++) a_say(32'h21 + 32'(i), 32'h50 + 32'(i), 1'b1);
        a_enq_rdy = 1'b1;
        tick();
        tick();
        a_say_ena = 1'b1; a_say_meth = 32'h25; a_say_v = 32'h55;
        #1;
        check("full_pop_no_bypass", 65'(a_say_rdy), 65'(0));
        tick();
        check("after_pop_rdy", 65'(a_say_rdy), 65'(1));
        a_exp(32'd1, 32'h25, 32'h55);
        tick();
        a_say_ena = 1'b0;
        drain(80, 1'b0);
        check("a_msg_sent_full", 65'(a_sent), 65'(12));

        // Toggling ready: beats held while low, none skipped or repeated.
        a_enq_rdy = 1'b0;
        a_say2_ena = 1'b1; a_say2_a = 32'hA1; a_say2_b = 32'hB2;
        a_exp(32'd2, 32'hA1, 32'hB2);
        tick();
        a_say2_ena = 1'b0;
        a_say(32'd3, 32'd4, 1'b1);
        drain(100, 1'b1);
        check("a_msg_sent_toggle", 65'(a_sent), 65'(14));

        // Reset mid-message: partial message discarded, restart from beat 0.
        a_say(32'd9, 32'd10, 1'b1);
        tick();
        rst = 1'b1;
        qa.delete();
        #1;
        check("midrst_enq_ena", 65'(a_enq_ena), 65'(0));
        check("midrst_enq_last", 65'(a_enq_last), 65'(0));
        check("midrst_msg_sent", 65'(a_sent), 65'(0));
        check("midrst_b_msg_sent", 65'(b_sent), 65'(0));
        check("midrst_say_rdy", 65'(a_say_rdy), 65'(1));
        tick();
        rst = 1'b0;
        tick();
        a_say(32'd11, 32'd12, 1'b1);
        drain(50, 1'b0);
        check("a_msg_sent_after_rst", 65'(a_sent), 65'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/echo_indication_serializer.md
ECHO_INDICATION_SERIALIZER -- requirements
Module: echo_indication_serializer

Interface
REQ-001 Parameter DATA_W, default 32, width of each method argument.
REQ-002 Parameter OUT_W, default 32, width of one output beat; SHALL divide 2*DATA_W+32.
REQ-003 Parameter DEPTH, default 4, message FIFO depth; power of two, >=2.
REQ-004 Derived constants: MSG_W = 32+2*DATA_W; BEATS = MSG_W/OUT_W.
REQ-005 Clocking: one clock; reset is asynchronous and active-high.
REQ-006 CLK  input  1  clock; all state on rising edge.
REQ-007 nRST  input  1  asynchronous reset, active-high despite the name.
REQ-008 say__ENA  input  1  method say invoked this cycle.
REQ-009 say_meth  input  DATA_W  say argument meth.
REQ-010 say_v  input  DATA_W  say argument v.
REQ-011 say__RDY  output  1  say may be invoked.
REQ-012 say2__ENA  input  1  method say2 invoked this cycle.
REQ-013 say2_a, say2_b  input  DATA_W each  say2 arguments.
REQ-014 say2__RDY  output  1  say2 may be invoked.
REQ-015 pipe$enq__ENA  output  1  beat valid.
REQ-016 pipe$enq_v  output  OUT_W  beat data.
REQ-017 pipe$enq_last  output  1  final beat of a message.
REQ-018 pipe$enq__RDY  input  1  downstream accepts beat.
REQ-019 msg_sent  output  16  count of fully transmitted messages.

Function
REQ-020 Message layout, LSB first: bits[31:0] tag, [32+:DATA_W] first argument, [32+DATA_W+:DATA_W] second argument.
REQ-021 say packs tag=1, meth, v; say2 packs tag=2, a, b.
REQ-022 say__RDY = !full; say2__RDY = !full && !say__ENA (say has priority; combinational).
REQ-023 A method is accepted only when ENA && RDY; ENA without RDY is ignored, no state change.
REQ-024 Accepted message written to FIFO tail on the same edge; visible at output no earlier than the next cycle.
REQ-025 pipe$enq__ENA = FIFO not empty; pipe$enq_v = head message bits [beat*OUT_W +: OUT_W].
REQ-026 beat counter advances on pipe$enq__ENA && pipe$enq__RDY; pipe$enq_last = (beat == BEATS-1).
REQ-027 On last beat accepted: beat -> 0, head pops, msg_sent increments (wraps 0xFFFF->0).
REQ-028 Push and pop in same cycle SHALL both occur; occupancy unchanged.
REQ-029 Full: no push accepted even if a pop occurs that cycle (no bypass).
REQ-030 Output data and beat stable while pipe$enq__RDY low (no mid-message drop).
REQ-031 Throughput: one beat per cycle when pipe$enq__RDY held high and FIFO non-empty.

Reset
REQ-032 Asserting nRST, at any time, empties FIFO, clears beat and msg_sent asynchronously; partial message is discarded.
REQ-033 During and after reset: pipe$enq__ENA=0, pipe$enq_last=0 (beat 0, empty), say__RDY=1, say2__RDY=1 unless say__ENA, msg_sent=0.
REQ-034 FIFO storage array is not reset; only pointers and counters.

Structure
REQ-035 Tag constants (SAY=1, SAY2=2) and MSG_W/BEATS derivations in shared package echo_ind_pkg.
REQ-036 Storage in one sub-module echo_msg_fifo (parameters MSG_W, DEPTH; push/pop/full/empty); serializer logic in top.

Verification
REQ-037 Defaults; say(meth=5,v=0x1234), RDY=1 -> beats 0x1,0x5,0x1234, last on third, msg_sent=1.
REQ-038 say and say2 both ENA same cycle -> only say accepted; say2__RDY=0 that cycle; say2 retried next cycle transmits after say.
REQ-039 pipe$enq__RDY=0, five say calls -> four accepted, say__RDY=0 after fourth; release RDY -> 12 beats in 12 cycles.
REQ-040 Toggle pipe$enq__RDY every cycle mid-message -> beat data held while low, no beat skipped or duplicated.
REQ-041 Assert nRST after beat 1 of a message -> pipe$enq__ENA=0 immediately, msg_sent=0; next say transmits from beat 0.
REQ-042 OUT_W=64, DATA_W=48 -> BEATS=2; say2(a=0xAAAA,b=0xBBBB) -> beat0={a[31:0],tag 2}, beat1={b,a[47:32]}, last on beat1.
